// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - RISC-V memory-access stage: BIOS/DMEM ports, store alignment, MMIO and MEM/WB register
module mem_stage #(
  parameter logic [31:0] NOP   = 32'h0000_0013,
  parameter int          CNT_W = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        mem_valid,
  input  logic [31:0] mem_inst,
  input  logic [31:0] mem_fp_inst,
  input  logic [31:0] mem_pc4,
  input  logic [31:0] mem_alu,
  input  logic [31:0] mem_fpu,
  input  logic [31:0] mem_rs2,
  output logic [11:0] bios_addr,
  output logic        bios_en,
  output logic [13:0] dmem_addr,
  output logic        dmem_en,
  output logic [3:0]  dmem_we,
  output logic [31:0] dmem_din,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ready,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready,
  output logic [31:0] wb_inst,
  output logic [31:0] wb_fp_inst,
  output logic [31:0] wb_pc4,
  output logic [31:0] wb_alu,
  output logic [31:0] wb_fpu,
  output logic [31:0] wb_io_dout
);

  localparam logic [6:0]  OP_LOAD  = 7'b0000011;
  localparam logic [6:0]  OP_FLW   = 7'b0000111;
  localparam logic [6:0]  OP_STORE = 7'b0100011;
  localparam logic [6:0]  OP_FSW   = 7'b0100111;
  localparam logic [31:0] IO_STAT  = 32'h8000_0000;
  localparam logic [31:0] IO_RX    = 32'h8000_0004;
  localparam logic [31:0] IO_TX    = 32'h8000_0008;
  localparam logic [31:0] IO_CYC   = 32'h8000_0010;
  localparam logic [31:0] IO_INST  = 32'h8000_0014;
  localparam logic [31:0] IO_CLR   = 32'h8000_0018;

  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] inst_cnt;

  logic [6:0]  opcode;
  logic [1:0]  size;
  logic        is_load;
  logic        is_store;
  logic        is_fsw;
  logic        in_dmem;
  logic        in_bios;
  logic        active;
  logic        commit;
  logic        cnt_clr;
  logic [31:0] st_din;
  logic [3:0]  st_we;
  logic [31:0] io_dout;

  assign opcode   = mem_inst[6:0];
  assign size     = mem_inst[13:12];
  assign is_fsw   = (opcode == OP_FSW);
  assign is_load  = (opcode == OP_LOAD) || (opcode == OP_FLW);
  assign is_store = (opcode == OP_STORE) || is_fsw;
  assign in_dmem  = (mem_alu[31:28] == 4'b0001) || (mem_alu[31:28] == 4'b0011);
  assign in_bios  = (mem_alu[31:28] == 4'b0100);

  // active: memory may be touched; commit: architectural side effects allowed
  assign active = rst_n && !stall;
  assign commit = active && !flush;

  assign bios_addr = mem_alu[13:2];
  assign dmem_addr = mem_alu[15:2];
  assign bios_en   = active && is_load && in_bios;
  assign dmem_en   = active && (is_load || is_store) && in_dmem;

  always_comb begin
    st_din = mem_rs2;
    st_we  = 4'b1111;
    if (!is_fsw) begin
      case (size)
        2'b00: begin
          st_din = {4{mem_rs2[7:0]}};
          st_we  = 4'b0001 << mem_alu[1:0];
        end
        2'b01: begin
          st_din = {2{mem_rs2[15:0]}};
          st_we  = 4'b0011 << {mem_alu[1], 1'b0};
        end
        default: begin
          st_din = mem_rs2;
          st_we  = 4'b1111;
        end
      endcase
    end
  end

  assign dmem_din = st_din;
  assign dmem_we  = (commit && is_store && in_dmem) ? st_we : 4'b0000;

  always_comb begin
    case (mem_alu)
      IO_STAT: io_dout = {30'b0, uart_rx_valid, uart_tx_ready};
      IO_RX:   io_dout = {24'b0, uart_rx_data};
      IO_CYC:  io_dout = 32'(cycle_cnt);
      IO_INST: io_dout = 32'(inst_cnt);
      default: io_dout = 32'b0;
    endcase
  end

  assign uart_rx_ready = commit && is_load && (mem_alu == IO_RX);
  assign uart_tx_valid = commit && is_store && (mem_alu == IO_TX) && uart_tx_ready;
  assign uart_tx_data  = mem_rs2[7:0];
  assign cnt_clr       = commit && is_store && (mem_alu == IO_CLR);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_inst    <= NOP;
      wb_fp_inst <= NOP;
      wb_pc4     <= 32'b0;
      wb_alu     <= 32'b0;
      wb_fpu     <= 32'b0;
      wb_io_dout <= 32'b0;
      cycle_cnt  <= '0;
      inst_cnt   <= '0;
    end else begin
      if (cnt_clr) begin
        cycle_cnt <= '0;
        inst_cnt  <= '0;
      end else begin
        cycle_cnt <= cycle_cnt + CNT_W'(1);
        if (commit && mem_valid) inst_cnt <= inst_cnt + CNT_W'(1);
      end
      if (!stall) begin
        if (flush) begin
          wb_inst    <= NOP;
          wb_fp_inst <= NOP;
          wb_pc4     <= 32'b0;
          wb_alu     <= 32'b0;
          wb_fpu     <= 32'b0;
          wb_io_dout <= 32'b0;
        end else begin
          wb_inst    <= mem_inst;
          wb_fp_inst <= mem_fp_inst;
          wb_pc4     <= mem_pc4;
          wb_alu     <= mem_alu;
          wb_fpu     <= mem_fpu;
          wb_io_dout <= io_dout;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage
module tb_mem_stage;

  localparam logic [31:0] NOP_I = 32'h0000_0013;
  localparam logic [31:0] I_SB  = 32'h0000_0023;
  localparam logic [31:0] I_SH  = 32'h0000_1023;
  localparam logic [31:0] I_SW  = 32'h0000_2023;
  localparam logic [31:0] I_FSW = 32'h0000_2027;
  localparam logic [31:0] I_LW  = 32'h0000_2003;
  localparam logic [31:0] I_ADD = 32'h00A0_0093;

  logic        clk = 1'b0;
  logic        rst_n, stall, flush, mem_valid;
  logic [31:0] mem_inst, mem_fp_inst, mem_pc4, mem_alu, mem_fpu, mem_rs2;
  logic [11:0] bios_addr;
  logic        bios_en;
  logic [13:0] dmem_addr;
  logic        dmem_en;
  logic [3:0]  dmem_we;
  logic [31:0] dmem_din;
  logic [7:0]  uart_rx_data;
  logic        uart_rx_valid, uart_rx_ready;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid, uart_tx_ready;
  logic [31:0] wb_inst, wb_fp_inst, wb_pc4, wb_alu, wb_fpu, wb_io_dout;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .mem_valid(mem_valid),
    .mem_inst(mem_inst), .mem_fp_inst(mem_fp_inst), .mem_pc4(mem_pc4),
    .mem_alu(mem_alu), .mem_fpu(mem_fpu), .mem_rs2(mem_rs2),
    .bios_addr(bios_addr), .bios_en(bios_en), .dmem_addr(dmem_addr),
    .dmem_en(dmem_en), .dmem_we(dmem_we), .dmem_din(dmem_din),
    .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid), .uart_rx_ready(uart_rx_ready),
    .uart_tx_data(uart_tx_data), .uart_tx_valid(uart_tx_valid), .uart_tx_ready(uart_tx_ready),
    .wb_inst(wb_inst), .wb_fp_inst(wb_fp_inst), .wb_pc4(wb_pc4),
    .wb_alu(wb_alu), .wb_fpu(wb_fpu), .wb_io_dout(wb_io_dout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mem(input logic [31:0] inst, input logic [31:0] alu, input logic [31:0] rs2);
    mem_inst = inst;
    mem_alu  = alu;
    mem_rs2  = rs2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; mem_valid = 1'b1; uart_tx_ready = 1'b1;
    set_mem(I_SW, 32'h1000_0000, 32'hDEAD_BEEF);
    #1;
    checks++; if (dmem_we !== 4'b0000) begin errors++; $display("FAIL rst_we got=%b exp=0000", dmem_we); end
    checks++; if (dmem_en !== 1'b0) begin errors++; $display("FAIL rst_dmem_en got=%b exp=0", dmem_en); end
    set_mem(I_SW, 32'h8000_0008, 32'h41);
    #1;
    checks++; if (uart_tx_valid !== 1'b0) begin errors++; $display("FAIL rst_tx_valid got=%b exp=0", uart_tx_valid); end
    tick();
    checks++; if (wb_inst !== NOP_I) begin errors++; $display("FAIL rst_wb_inst got=%h exp=%h", wb_inst, NOP_I); end
    checks++; if (wb_fp_inst !== NOP_I) begin errors++; $display("FAIL rst_wb_fp_inst got=%h exp=%h", wb_fp_inst, NOP_I); end
    checks++; if (wb_alu !== 32'h0) begin errors++; $display("FAIL rst_wb_alu got=%h exp=0", wb_alu); end
    rst_n = 1'b1; mem_valid = 1'b0;
    set_mem(I_LW, 32'h8000_0010, 32'h0);
    tick();
    checks++; if (wb_io_dout !== 32'h0) begin errors++; $display("FAIL rst_cycle_cnt got=%h exp=0", wb_io_dout); end
  endtask

  task automatic test_store();
    stall = 1'b0; flush = 1'b0; mem_valid = 1'b0;
    set_mem(I_SB, 32'h1000_0006, 32'h0000_00AB); mem_pc4 = 32'h104;
    #1;
    checks++; if (dmem_we !== 4'b0100) begin errors++; $display("FAIL sb_we got=%b exp=0100", dmem_we); end
    checks++; if (dmem_din !== 32'hABAB_ABAB) begin errors++; $display("FAIL sb_din got=%h exp=ababab ab", dmem_din); end
    checks++; if (dmem_addr !== 14'h0001) begin errors++; $display("FAIL sb_addr got=%h exp=0001", dmem_addr); end
    checks++; if (dmem_en !== 1'b1) begin errors++; $display("FAIL sb_en got=%b exp=1", dmem_en); end
    tick();
    checks++; if (wb_pc4 !== 32'h104) begin errors++; $display("FAIL sb_wb_pc4 got=%h exp=104", wb_pc4); end
    set_mem(I_SH, 32'h1000_0002, 32'h0000_1234);
    #1;
    checks++; if (dmem_we !== 4'b1100) begin errors++; $display("FAIL sh_we got=%b exp=1100", dmem_we); end
    checks++; if (dmem_din !== 32'h1234_1234) begin errors++; $display("FAIL sh_din got=%h exp=12341234", dmem_din); end
    tick();
    set_mem(I_SB, 32'h3000_0001, 32'h0000_0077);
    #1;
    checks++; if (dmem_we !== 4'b0010) begin errors++; $display("FAIL sb3_we got=%b exp=0010", dmem_we); end
    tick();
    set_mem(I_FSW, 32'h1000_000B, 32'hCAFE_F00D);
    #1;
    checks++; if (dmem_we !== 4'b1111) begin errors++; $display("FAIL fsw_we got=%b exp=1111", dmem_we); end
    checks++; if (dmem_din !== 32'hCAFE_F00D) begin errors++; $display("FAIL fsw_din got=%h exp=cafef00d", dmem_din); end
    tick();
    set_mem(I_SW, 32'h4000_0000, 32'h1);
    #1;
    checks++; if ({bios_en, dmem_en, dmem_we} !== 6'b0) begin errors++; $display("FAIL bios_store got=%b exp=000000", {bios_en, dmem_en, dmem_we}); end
    tick();
    set_mem(I_LW, 32'h4000_0010, 32'h0);
    #1;
    checks++; if ({bios_en, dmem_en} !== 2'b10) begin errors++; $display("FAIL bios_load_en got=%b exp=10", {bios_en, dmem_en}); end
    checks++; if (bios_addr !== 12'h004) begin errors++; $display("FAIL bios_addr got=%h exp=004", bios_addr); end
    stall = 1'b1;
    #1;
    checks++; if (bios_en !== 1'b0) begin errors++; $display("FAIL bios_stall_en got=%b exp=0", bios_en); end
    stall = 1'b0;
    set_mem(I_LW, 32'h1000_0010, 32'h0);
    #1;
    checks++; if ({dmem_en, dmem_we} !== 5'b10000) begin errors++; $display("FAIL dmem_load got=%b exp=10000", {dmem_en, dmem_we}); end
    tick();
  endtask

  task automatic test_uart_rx();
    stall = 1'b0; flush = 1'b0;
    uart_rx_valid = 1'b1; uart_rx_data = 8'h5A; uart_tx_ready = 1'b0;
    set_mem(I_LW, 32'h8000_0004, 32'h0);
    #1;
    checks++; if (uart_rx_ready !== 1'b1) begin errors++; $display("FAIL rx_ready got=%b exp=1", uart_rx_ready); end
    tick();
    checks++; if (wb_io_dout !== 32'h0000_005A) begin errors++; $display("FAIL rx_data got=%h exp=5a", wb_io_dout); end
    stall = 1'b1;
    #1;
    checks++; if (uart_rx_ready !== 1'b0) begin errors++; $display("FAIL rx_stall got=%b exp=0", uart_rx_ready); end
    stall = 1'b0; flush = 1'b1;
    #1;
    checks++; if (uart_rx_ready !== 1'b0) begin errors++; $display("FAIL rx_flush got=%b exp=0", uart_rx_ready); end
    flush = 1'b0;
    set_mem(I_LW, 32'h8000_0000, 32'h0);
    tick();
    checks++; if (wb_io_dout !== 32'h2) begin errors++; $display("FAIL uart_status got=%h exp=2", wb_io_dout); end
    uart_rx_valid = 1'b0;
  endtask

  task automatic test_uart_tx();
    stall = 1'b0; flush = 1'b0; uart_tx_ready = 1'b1;
    set_mem(I_SW, 32'h8000_0008, 32'h0000_0041);
    #1;
    checks++; if (uart_tx_valid !== 1'b1) begin errors++; $display("FAIL tx_valid got=%b exp=1", uart_tx_valid); end
    checks++; if (uart_tx_data !== 8'h41) begin errors++; $display("FAIL tx_data got=%h exp=41", uart_tx_data); end
    uart_tx_ready = 1'b0;
    #1;
    checks++; if (uart_tx_valid !== 1'b0) begin errors++; $display("FAIL tx_not_ready got=%b exp=0", uart_tx_valid); end
    tick();
  endtask

  task automatic test_counters();
    flush = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; mem_valid = 1'b1;
    set_mem(NOP_I, 32'h0, 32'h0);
    for (int i = 0; i < 10; i++) begin
      stall = (i < 3);
      tick();
    end
    stall = 1'b0; mem_valid = 1'b0;
    set_mem(I_LW, 32'h8000_0010, 32'h0);
    tick();
    checks++; if (wb_io_dout !== 32'd10) begin errors++; $display("FAIL cycle_cnt got=%0d exp=10", wb_io_dout); end
    set_mem(I_LW, 32'h8000_0014, 32'h0);
    tick();
    checks++; if (wb_io_dout !== 32'd7) begin errors++; $display("FAIL inst_cnt got=%0d exp=7", wb_io_dout); end
    set_mem(I_SW, 32'h8000_0018, 32'h0);
    tick();
    set_mem(I_LW, 32'h8000_0010, 32'h0);
    tick();
    checks++; if (wb_io_dout !== 32'd0) begin errors++; $display("FAIL cycle_clr got=%0d exp=0", wb_io_dout); end
    set_mem(I_LW, 32'h8000_0014, 32'h0);
    tick();
    checks++; if (wb_io_dout !== 32'd0) begin errors++; $display("FAIL inst_clr got=%0d exp=0", wb_io_dout); end
  endtask

  task automatic test_flush();
    stall = 1'b0; flush = 1'b0; mem_valid = 1'b0;
    set_mem(I_SW, 32'h8000_0018, 32'h0);
    tick();
    mem_valid = 1'b1; flush = 1'b1;
    set_mem(I_SW, 32'h1000_0000, 32'h55);
    #1;
    checks++; if (dmem_we !== 4'b0000) begin errors++; $display("FAIL flush_we got=%b exp=0000", dmem_we); end
    set_mem(I_ADD, 32'h0000_1234, 32'h0);
    tick();
    checks++; if (wb_inst !== NOP_I) begin errors++; $display("FAIL flush_wb_inst got=%h exp=%h", wb_inst, NOP_I); end
    checks++; if (wb_alu !== 32'h0) begin errors++; $display("FAIL flush_wb_alu got=%h exp=0", wb_alu); end
    flush = 1'b0; mem_valid = 1'b0;
    set_mem(I_LW, 32'h8000_0014, 32'h0);
    tick();
    checks++; if (wb_io_dout !== 32'h0) begin errors++; $display("FAIL flush_inst_cnt got=%0d exp=0", wb_io_dout); end
    set_mem(I_ADD, 32'h0000_1234, 32'h0); mem_pc4 = 32'h200;
    tick();
    checks++; if (wb_inst !== I_ADD) begin errors++; $display("FAIL pass_wb_inst got=%h exp=%h", wb_inst, I_ADD); end
    stall = 1'b1; flush = 1'b1;
    set_mem(I_SW, 32'h1000_0004, 32'h0); mem_pc4 = 32'h300;
    tick();
    checks++; if (wb_inst !== I_ADD) begin errors++; $display("FAIL stallflush_inst got=%h exp=%h", wb_inst, I_ADD); end
    checks++; if (wb_pc4 !== 32'h200) begin errors++; $display("FAIL stallflush_pc4 got=%h exp=200", wb_pc4); end
    stall = 1'b0; flush = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; mem_valid = 1'b0;
    mem_inst = NOP_I; mem_fp_inst = NOP_I; mem_pc4 = 32'h0; mem_alu = 32'h0;
    mem_fpu = 32'h0; mem_rs2 = 32'h0;
    uart_rx_data = 8'h0; uart_rx_valid = 1'b0; uart_tx_ready = 1'b0;
    test_reset();
    test_store();
    test_uart_rx();
    test_uart_tx();
    test_counters();
    test_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the RISC-V pipeline; sits directly upstream of the writeback stage.
- Decodes the effective address from the ALU and drives the synchronous BIOS and DMEM ports, whose read data lands in writeback one cycle later.
- Generates aligned store data and byte enables, and owns the MMIO space: UART handshake, cycle counter, and retired-instruction counter.
- Registers the MEM/WB pipeline fields, including a registered IO read value aligned with the memory outputs.

Parameters:
- NOP, 32'h0000_0013, instruction injected on reset and flush.
- CNT_W, 32, width of the cycle and instruction counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- stall  in  1  hold the pipeline; no memory or MMIO side effects
- flush  in  1  inject a bubble into WB
- mem_valid  in  1  the instruction in MEM is real (counts toward retirement)
- mem_inst, mem_fp_inst  in  32 each  instructions in MEM
- mem_pc4, mem_alu, mem_fpu  in  32 each  PC+4, address/ALU result, FPU result
- mem_rs2  in  32  store data (int/fp already selected)
- bios_addr  out  12  word address = mem_alu[13:2]
- bios_en  out  1  BIOS read enable
- dmem_addr  out  14  word address = mem_alu[15:2]
- dmem_en  out  1  DMEM enable
- dmem_we  out  4  byte write enables
- dmem_din  out  32  lane-aligned store data
- uart_rx_data  in  8  received byte
- uart_rx_valid  in  1  received byte available
- uart_rx_ready  out  1  consume received byte
- uart_tx_data  out  8  byte to transmit
- uart_tx_valid  out  1  transmit request
- uart_tx_ready  in  1  transmitter can accept a byte
- wb_inst, wb_fp_inst, wb_pc4, wb_alu, wb_fpu, wb_io_dout  out  32 each  MEM/WB register outputs

Behaviour:
- Address decode on mem_alu[31:28]:
  - 0001 or 0011: DMEM
  - 0100: BIOS (read-only; stores ignored)
  - 1000: IO
  - anything else: no access
- Load = opcode 0000011, or 0000111 (flw). Store = opcode 0100011, or 0100111 (fsw, treated as sw).
- bios_en / dmem_en are asserted combinationally for a load to their region while !stall. dmem_en is also asserted for a store to DMEM. Both are 0 during stall so memory output holds.
- Store alignment, with o = mem_alu[1:0]:
  - sb: din = {4{rs2[7:0]}}, we = 4'b0001 << o
  - sh: din = {2{rs2[15:0]}}, we = 4'b0011 << {o[1],1'b0}
  - sw: din = rs2, we = 4'b1111
  - Misaligned o bits are ignored (truncated).
  - we = 0 on stall, flush, a non-store, or a non-DMEM address.
- IO read map (combinational, registered into wb_io_dout):
  - 8000_0000: {30'b0, uart_rx_valid, uart_tx_ready}
  - 8000_0004: {24'b0, uart_rx_data}
  - 8000_0010: cycle counter
  - 8000_0014: instruction counter
  - any other address: 0
- UART RX: uart_rx_ready = 1 combinationally, for one cycle, when a load to 8000_0004 is in MEM and !stall && !flush.
- UART TX: a store to 8000_0008 with !stall && !flush && uart_tx_ready drives uart_tx_valid = 1 and uart_tx_data = mem_rs2[7:0] in the same cycle. If uart_tx_ready = 0 the write is dropped; software polls.
- Counter reset: a store to 8000_0018 (!stall && !flush) clears both counters at the next edge. The clear takes precedence over increment, so both read 0 on the following cycle.
- Cycle counter increments every cycle, including during stall. Both counters wrap modulo 2^CNT_W.
- Instruction counter increments when mem_valid && !stall && !flush.
- Pipeline register priority, highest first:
  1. !rst_n: wb_inst = wb_fp_inst = NOP; all other wb_* = 0; counters = 0.
  2. stall: all wb_* hold.
  3. flush: wb_inst = wb_fp_inst = NOP; other fields are don't-care but loaded with 0.
  4. Otherwise wb_* <= mem_*, and wb_io_dout <= IO read value.
- Stall and flush together: stall wins; the flush is reapplied by hazard logic.
- Reset values of combinational outputs: all enables, we, uart_rx_ready, and uart_tx_valid are 0 whenever rst_n = 0.
- Latency: load data from all three sources is valid in WB exactly one cycle after MEM.

Test Plan:
- sb x5=0xAB to 0x1000_0006 -> dmem_we=0100, dmem_din=0xABABABAB, dmem_addr=0x0001; sh to 0x1000_0002 -> we=1100.
- lw 0x8000_0004 with rx_valid=1, rx_data=0x5A -> uart_rx_ready pulses 1 cycle; next cycle wb_io_dout=0x0000005A; same load during stall -> no pulse.
- sw 0x41 to 0x8000_0008 with tx_ready=1 -> tx_valid=1, tx_data=0x41; with tx_ready=0 -> tx_valid stays 0.
- Reset, run 10 cycles with 3 stalls and 7 valid instructions -> read 0x8000_0010 returns 10 (±pipeline offset as documented) and 0x8000_0014 returns 7; store to 0x8000_0018 -> both 0 next cycle.
- flush with mem_inst=0x00A00093 -> wb_inst=0x00000013, no store, no counter increment; stall+flush -> wb_* unchanged.
- rst_n=0 mid-store -> dmem_we=0, wb_inst=NOP, counters=0 after the edge; store to 0x4000_0000 -> no enables asserted.
